// File: rtl/axi_lite_regfile.sv
// AXI4-Lite responder with six read/write words, a write counter and a constant ID word.
// All handshake and response outputs come straight from flops; nothing is combinational from inputs.
module axi_lite_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter logic [31:0] ID_VALUE   = 32'hA11E0001
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (32'(a) >= 32'h20);
    endfunction

    w_state_t                w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
    logic                    bvalid_q, bvalid_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic [DATA_WIDTH-1:0]   regs_q [0:5];
    logic [DATA_WIDTH-1:0]   regs_d [0:5];
    logic [DATA_WIDTH-1:0]   wr_count_q, wr_count_d;

    r_state_t                r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
    logic                    rvalid_q, rvalid_d;
    logic                    arready_q, arready_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [2:0]              w_idx, r_idx;

    always_comb begin
        w_state_d  = w_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        commit     = 1'b0;
        aw_hs      = s0_axi_awvalid && awready_q;
        w_hs       = s0_axi_wvalid && wready_q;

        if (aw_hs) begin
            awaddr_d = s0_axi_awaddr;
        end
        if (w_hs) begin
            wdata_d = s0_axi_wdata;
            wstrb_d = s0_axi_wstrb;
        end

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_RESP: begin
                if (s0_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // The _d copies already merge this cycle's handshake with anything latched earlier.
        w_idx = awaddr_d[4:2];
        if (commit) begin
            if (addr_err(awaddr_d) || (w_idx >= 3'd6)) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d    = RESP_OKAY;
                wr_count_d = wr_count_q + DATA_WIDTH'(1);
                for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                    if (wstrb_d[i]) begin
                        regs_d[w_idx][8*i +: 8] = wdata_d[8*i +: 8];
                    end
                end
            end
        end

        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_hs     = s0_axi_arvalid && arready_q;
        r_idx     = s0_axi_araddr[4:2];

        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (s0_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase

        // Reads sample the pre-edge register values, so a same-edge write is not visible.
        if (ar_hs) begin
            if (addr_err(s0_axi_araddr)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rresp_d = RESP_OKAY;
                case (r_idx)
                    3'd6:    rdata_d = wr_count_q;
                    3'd7:    rdata_d = DATA_WIDTH'(ID_VALUE);
                    default: rdata_d = regs_q[r_idx];
                endcase
            end
        end

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            w_state_q  <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= arready_d;
        end
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_arready = arready_q;
    assign s0_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = rresp_q;
    assign s0_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed and randomized AXI4-Lite traffic against a word-array model of the register file.
module tb_axi_lite_regfile;

    localparam logic [31:0] ID = 32'hA11E0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  bresp, rresp;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] m_reg [8];

    axi_lite_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESP_WIDTH(3),
        .ID_VALUE  (ID)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (rst),
        .s0_axi_awaddr (awaddr),
        .s0_axi_awvalid(awvalid),
        .s0_axi_awready(awready),
        .s0_axi_wdata  (wdata),
        .s0_axi_wstrb  (wstrb),
        .s0_axi_wvalid (wvalid),
        .s0_axi_wready (wready),
        .s0_axi_bresp  (bresp),
        .s0_axi_bvalid (bvalid),
        .s0_axi_bready (bready),
        .s0_axi_araddr (araddr),
        .s0_axi_arvalid(arvalid),
        .s0_axi_arready(arready),
        .s0_axi_rdata  (rdata),
        .s0_axi_rresp  (rresp),
        .s0_axi_rvalid (rvalid),
        .s0_axi_rready (rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 7; i++) m_reg[i] = '0;
        m_reg[7] = ID;
    endfunction

    function automatic bit m_err(input logic [7:0] a);
        return (a % 4 != 0) || (a >= 8'h20);
    endfunction

    function automatic logic [2:0] m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = a / 4;
        if (m_err(a) || w >= 6) return 3'd2;
        for (int i = 0; i < 4; i++)
            if (s[i]) m_reg[w][8*i +: 8] = d[8*i +: 8];
        m_reg[6] = m_reg[6] + 32'd1;
        return 3'd0;
    endfunction

    function automatic void m_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
        if (m_err(a)) begin
            d = '0;
            r = 3'd2;
        end else begin
            d = m_reg[a / 4];
            r = 3'd0;
        end
    endfunction

    // mode 0: AW and W together; 1: AW first, W after gap cycles; 2: W first, AW after gap cycles
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input int gap, input int bdelay);
        logic [2:0] exp;
        bit aw_done, w_done, hs_aw, hs_w;
        int t;
        aw_done = 0;
        w_done  = 0;
        t       = 0;
        exp     = m_write(a, d, s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = (mode != 2);
        wvalid  = (mode != 1);
        while (!(aw_done && w_done) && t < 40) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            t++;
            if (hs_aw) begin aw_done = 1; awvalid = 0; end
            if (hs_w)  begin w_done = 1;  wvalid = 0;  end
            if (t == gap) begin
                if (mode == 2 && !aw_done) awvalid = 1;
                if (mode == 1 && !w_done)  wvalid = 1;
            end
        end
        awvalid = 0;
        wvalid  = 0;
        check("aw_w_handshake", {aw_done, w_done}, 2'b11);
        check("bvalid_after_hs", bvalid, 1);
        check("bresp", bresp, exp);
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            check("bvalid_awready_wready_hold", {bvalid, awready, wready}, 3'b100);
            check("bresp_hold", bresp, exp);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("b_done_ready_again", {bvalid, awready, wready}, 3'b011);
    endtask

    task automatic axi_read(input logic [7:0] a, input int rdelay, output logic [31:0] d);
        logic [31:0] ed;
        logic [2:0]  er;
        bit hs, done;
        int t;
        done = 0;
        t    = 0;
        m_read(a, ed, er);
        araddr  = a;
        arvalid = 1;
        while (!done && t < 40) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            t++;
            if (hs) done = 1;
        end
        arvalid = 0;
        check("ar_handshake", done, 1);
        check("rvalid_after_ar", {rvalid, arready}, 2'b10);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        d = rdata;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            check("rdata_hold", rdata, ed);
            check("rvalid_hold", {rvalid, rresp}, {1'b1, er});
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("r_done", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        logic [31:0] d, old, ed;
        logic [2:0]  er, eb;
        logic [7:0]  a;

        rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
        check("reset_bresp", bresp, 0);
        check("reset_rresp", rresp, 0);
        check("reset_rdata", rdata, 0);
        rst = 0;
        @(posedge clk); #1;
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        // Same-cycle AW+W, then read back and check the write counter
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 1, 0);
        axi_read(8'h04, 0, d);
        check("req033_reg1", d, 32'hDEADBEEF);
        axi_read(8'h18, 0, d);
        check("req033_wrcount", d, 32'd1);

        // W first, AW three cycles later, partial strobes
        axi_write(8'h00, 32'h11223344, 4'h5, 2, 3, 0);
        axi_read(8'h00, 1, d);
        check("req034_reg0", d, 32'h00220044);

        // Read-only and error addresses
        axi_write(8'h1C, 32'h12345678, 4'hF, 1, 2, 0);
        axi_read(8'h1C, 0, d);
        check("req035_id", d, ID);
        axi_read(8'h22, 0, d);
        check("req035_err_rdata", d, 0);

        // Zero strobe still counts as an OKAY write but leaves data alone
        axi_write(8'h04, 32'h0, 4'h0, 0, 1, 0);
        axi_read(8'h04, 0, d);
        check("zero_strb_reg1", d, 32'hDEADBEEF);

        // Response back-pressure
        axi_write(8'h0C, $urandom, 4'hF, 1, 2, 5);

        // Same-edge read and write commit to register 2
        axi_write(8'h08, 32'hCAFEF00D, 4'hF, 0, 1, 0);
        m_read(8'h08, old, er);
        awaddr = 8'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h08; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        eb = m_write(8'h08, 32'h55, 4'hF);
        check("coll_valids", {bvalid, rvalid}, 2'b11);
        check("coll_bresp", bresp, eb);
        check("coll_rdata_old", rdata, old);
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        axi_read(8'h08, 0, d);
        check("coll_rdata_new", d, 32'h55);

        // Randomized mixed traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
            else a = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
            else
                axi_read(a, int'($urandom_range(0, 2)), d);
        end
        axi_read(8'h18, 0, d);

        // Reset while both responses are pending
        awaddr = 8'h10; wdata = $urandom; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h00; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        eb = m_write(8'h10, wdata, 4'hF);
        check("pre_reset_valids", {bvalid, rvalid}, 2'b11);
        rst = 1;
        @(posedge clk); #1;
        check("mid_reset_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
        check("mid_reset_data", {rdata[28:0], bresp}, 0);
        rst = 0;
        m_reset();
        @(posedge clk); #1;
        check("ready_after_reset2", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(i * 4), 0, d);
            ed = (i == 7) ? ID : 32'h0;
            check("post_reset_reg", d, ed);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
